// File: rtl/ifetch_queue.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests and queues returned words for decode.
// Optional perf counters (redirect count, starve cycles) are built when IFQ_PERF_EN is defined.
module ifetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_addr,
  input  logic                       imem_rsp_valid,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       dec_valid,
  output logic [31:0]                dec_inst,
  output logic [XLEN-1:0]            dec_pc4,
  input  logic                       dec_ready,
  output logic [XLEN-1:0]            pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
`ifdef IFQ_PERF_EN
  output logic [31:0]                perf_flush,
  output logic [31:0]                perf_starve,
`endif
  output logic                       dbg_state,
  output logic [$clog2(DEPTH+1)-1:0] dbg_outstanding
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   outstanding_q, outstanding_d, drop_q, count_q;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q, tag_rd_q, tag_wr_q;
  logic [31:0]     inst_mem [DEPTH];
  logic [XLEN-1:0] pc4_mem  [DEPTH];
  logic [XLEN-1:0] tag_mem  [DEPTH];

  logic credit_ok, accept, rsp_take, rsp_drop, push, pop;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high; valid never
  // depends on the matching ready. imem responses carry no ready and arrive in request order.
  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, count_q}) < (CW + 1)'(DEPTH);
  assign imem_req_valid = reset && (state_q == FETCH) && credit_ok;
  assign accept   = imem_req_valid && imem_req_ready;
  assign rsp_take = imem_rsp_valid && (outstanding_q != '0);
  assign rsp_drop = rsp_take && (drop_q != '0);
  assign push     = rsp_take && !rsp_drop && !redirect_valid;
  assign pop      = dec_valid && dec_ready && !redirect_valid;

  assign outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_take);

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: state_d = FETCH;
      DRAIN: if ((drop_q == '0) || ((drop_q == CW'(1)) && rsp_drop)) state_d = FETCH;
      default: state_d = FETCH;
    endcase
    if (redirect_valid) state_d = DRAIN;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      if (accept) tag_wr_q <= tag_wr_q + PW'(1);
      if (rsp_take) tag_rd_q <= tag_rd_q + PW'(1);
      // A redirect squashes everything in flight, including a request accepted this same cycle.
      if (redirect_valid) begin
        pc_q     <= redirect_pc;
        drop_q   <= outstanding_d;
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (accept) pc_q <= pc_q + XLEN'(PC_STEP);
        if (rsp_drop) drop_q <= drop_q - CW'(1);
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) tag_mem[tag_wr_q] <= pc_q;
    if (push) begin
      inst_mem[wr_ptr_q] <= imem_rdata;
      pc4_mem[wr_ptr_q]  <= tag_mem[tag_rd_q] + XLEN'(PC_STEP);
    end
  end

  assign imem_addr       = pc_q;
  assign pc              = pc_q;
  assign dec_valid       = (count_q != '0);
  assign dec_inst        = inst_mem[rd_ptr_q];
  assign dec_pc4         = pc4_mem[rd_ptr_q];
  assign occupancy       = count_q;
  assign dbg_state       = state_q;
  assign dbg_outstanding = outstanding_q;

`ifdef IFQ_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_flush  <= '0;
      perf_starve <= '0;
    end else begin
      if (redirect_valid && (perf_flush != '1)) perf_flush <= perf_flush + 32'd1;
      if (!dec_valid && (state_q == FETCH) && (perf_starve != '1)) perf_starve <= perf_starve + 32'd1;
    end
  end
`endif

  a_rsp_outstanding: assert property (@(posedge clk) disable iff (!reset)
    imem_rsp_valid |-> (outstanding_q != '0));

endmodule
